// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl - raster timing controller for a 480x272 parallel-RGB LCD.
//
// Stage 0 runs the horizontal/vertical counters and presents pos_x/pos_y to
// an external pattern generator, which answers combinationally on
// red/green/blue. Stage 1 registers that colour together with sync/DE, so all
// LCD pins change on the same edge, one clock after pos_x/pos_y.
// The pattern select is frame-synchronous. It updates only on the last clock
// of a frame, so a new pattern starts at pixel (0,0) and never tears.
//
// Build option: define LCD_PATTERN_AUTO_EN to cycle the pattern automatically
// every FRAMES_PER_PATTERN frames. In that build pattern_sel is ignored. By
// default the pattern follows pattern_sel, sampled at each frame boundary.
//
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   pattern_sel[1:0]    requested pattern (manual build)
//   red/green/blue[7:0] colour for the current pos_x/pos_y (combinational)
//   pos_x[9:0]          current column (0 outside active area)
//   pos_y[8:0]          current row    (0 outside active area)
//   pattern[1:0]        active pattern code
//   lcd_de              data enable, active-high
//   lcd_hsync/lcd_vsync active-low syncs
//   lcd_r/g/b[7:0]      registered pixel data, 0 outside active area
//   frame_start         one-clock pulse with the first active pixel on the pins
module lcd_timing_ctrl #(
  parameter int H_ACTIVE           = 480,
  parameter int H_FP               = 2,
  parameter int H_SYNC             = 41,
  parameter int H_BP               = 2,
  parameter int V_ACTIVE           = 272,
  parameter int V_FP               = 2,
  parameter int V_SYNC             = 10,
  parameter int V_BP               = 2,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic [1:0] pattern,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [7:0] lcd_r,
  output logic [7:0] lcd_g,
  output logic [7:0] lcd_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the window edges, so the compares are width-matched.
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_END = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_ACT = 9'(V_ACTIVE);
  localparam logic [8:0] V_SS  = 9'(V_ACTIVE + V_FP);
  localparam logic [8:0] V_SE  = 9'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [8:0] V_END = 9'(V_TOTAL - 1);

  // Elaboration-time sanity checks on the geometry.
  if (H_TOTAL > 1024) begin : g_chk_h
    $error("H_TOTAL exceeds 10-bit counter");
  end
  if (V_TOTAL > 512) begin : g_chk_v
    $error("V_TOTAL exceeds 9-bit counter");
  end
  if (FRAMES_PER_PATTERN < 1) begin : g_chk_f
    $error("FRAMES_PER_PATTERN must be >= 1");
  end

  // ---------------- stage 0: raster counters ----------------
  logic [9:0] h_cnt;
  logic [8:0] v_cnt;
  logic       h_last, frame_end;
  logic       h_act, v_act, active0;
  logic       h_sync_win, v_sync_win;

  assign h_last     = (h_cnt == H_END);
  assign frame_end  = h_last && (v_cnt == V_END);
  assign h_act      = (h_cnt < H_ACT);
  assign v_act      = (v_cnt < V_ACT);
  assign active0    = h_act && v_act;
  assign h_sync_win = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign v_sync_win = (v_cnt >= V_SS) && (v_cnt < V_SE);

  assign pos_x = h_act ? h_cnt : '0;
  assign pos_y = v_act ? v_cnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + 9'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // ---------------- stage 1: pin registers ----------------
  // The vsync window covers whole lines, so it stays low for every clock of
  // each sync line, porches included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      lcd_de      <= active0;
      lcd_hsync   <= ~h_sync_win;
      lcd_vsync   <= ~v_sync_win;
      lcd_r       <= active0 ? red   : '0;
      lcd_g       <= active0 ? green : '0;
      lcd_b       <= active0 ? blue  : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // ---------------- frame-synchronous pattern select ----------------
`ifdef LCD_PATTERN_AUTO_EN
  localparam int FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_PATTERN - 1);

  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      pattern   <= '0;
    end else if (frame_end) begin
      if (frame_cnt == F_LAST) begin
        frame_cnt <= '0;
        pattern   <= pattern + 2'd1;  // wraps 3 -> 0
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pattern <= '0;
    else if (frame_end) pattern <= pattern_sel;
  end
`endif

endmodule
